// File: rtl/uart_rx_pkg.sv
// +--------------------------------------------------------------------+
// | uart_rx_pkg : shared encodings for the UART receive path           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package uart_rx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } rx_state_t;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  // Shared with the TX parity calculator.
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sampler.sv
// +--------------------------------------------------------------------+
// | uart_rx_sampler : per-bit edge counter with 3-sample majority vote |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module uart_rx_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  bit_done,
  output logic                  vote_ready,
  output logic                  bit_val
);

  localparam logic [PRESCALE_W-1:0] c_one = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] c_two = PRESCALE_W'(2);

  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [2:0]            r_samples;
  logic [PRESCALE_W-1:0] w_half;
  logic [PRESCALE_W-1:0] w_last;

  assign w_half = prescale >> 1;
  assign w_last = prescale - c_one;

  // Counter idles at zero so the first cycle of a bit state is edge 0.
  always_ff @(posedge clk) begin
    if (!rst || !en) begin
      r_edge_cnt <= '0;
      r_samples  <= '0;
    end else begin
      if (r_edge_cnt == w_last) begin
        r_edge_cnt <= '0;
      end else begin
        r_edge_cnt <= r_edge_cnt + c_one;
      end
      if (r_edge_cnt == w_half - c_one) r_samples[0] <= rx_in;
      if (r_edge_cnt == w_half)         r_samples[1] <= rx_in;
      if (r_edge_cnt == w_half + c_one) r_samples[2] <= rx_in;
    end
  end

  assign bit_done   = en && (r_edge_cnt == w_last);
  assign vote_ready = en && (r_edge_cnt == w_half + c_two);
  assign bit_val    = (r_samples[0] & r_samples[1]) |
                      (r_samples[0] & r_samples[2]) |
                      (r_samples[1] & r_samples[2]);

endmodule

`default_nettype wire

// File: rtl/uart_rx_fsm.sv
// +--------------------------------------------------------------------+
// | uart_rx_fsm : UART receiver, frame FSM with parity and stop checks |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int c_cnt_w = $clog2(DATA_WIDTH > 1 ? DATA_WIDTH : 2);
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_WIDTH - 1);

  rx_state_t             r_state,      w_state_nxt;
  logic [c_cnt_w-1:0]    r_bit_cnt,    w_bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_shift,      w_shift_nxt;
  logic [DATA_WIDTH-1:0] r_p_data,     w_p_data_nxt;
  logic                  r_par_pend,   w_par_pend_nxt;
  logic [PRESCALE_W-1:0] r_prescale,   w_prescale_nxt;
  logic                  r_par_en,     w_par_en_nxt;
  logic                  r_par_typ,    w_par_typ_nxt;
  logic                  r_data_valid, w_data_valid_nxt;
  logic                  r_par_err,    w_par_err_nxt;
  logic                  r_stp_err,    w_stp_err_nxt;

  logic                  w_bit_done;
  logic                  w_vote_ready;
  logic                  w_bit_val;
  logic [PRESCALE_W-1:0] w_prescale_legal;

  assign w_prescale_legal =
    (prescale == PRESCALE_W'(PRESCALE_16) || prescale == PRESCALE_W'(PRESCALE_32))
      ? prescale : PRESCALE_W'(PRESCALE_8);

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .en         (r_state != IDLE),
    .rx_in      (rx_in),
    .prescale   (r_prescale),
    .bit_done   (w_bit_done),
    .vote_ready (w_vote_ready),
    .bit_val    (w_bit_val)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_p_data     <= '0;
      r_par_pend   <= 1'b0;
      r_prescale   <= PRESCALE_W'(PRESCALE_8);
      r_par_en     <= 1'b0;
      r_par_typ    <= PARITY_EVEN;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_p_data     <= w_p_data_nxt;
      r_par_pend   <= w_par_pend_nxt;
      r_prescale   <= w_prescale_nxt;
      r_par_en     <= w_par_en_nxt;
      r_par_typ    <= w_par_typ_nxt;
      r_data_valid <= w_data_valid_nxt;
      r_par_err    <= w_par_err_nxt;
      r_stp_err    <= w_stp_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_shift_nxt      = r_shift;
    w_p_data_nxt     = r_p_data;
    w_par_pend_nxt   = r_par_pend;
    w_prescale_nxt   = r_prescale;
    w_par_en_nxt     = r_par_en;
    w_par_typ_nxt    = r_par_typ;
    w_data_valid_nxt = 1'b0;
    w_par_err_nxt    = 1'b0;
    w_stp_err_nxt    = 1'b0;

    case (r_state)
      IDLE: begin
        // Frame configuration is frozen at the start edge.
        if (!rx_in) begin
          w_state_nxt    = START;
          w_bit_cnt_nxt  = '0;
          w_par_pend_nxt = 1'b0;
          w_prescale_nxt = w_prescale_legal;
          w_par_en_nxt   = par_en;
          w_par_typ_nxt  = par_typ;
        end
      end
      START: begin
        if (w_vote_ready && w_bit_val) begin
          w_state_nxt = IDLE;
        end else if (w_bit_done) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_bit_done) begin
          w_shift_nxt = {w_bit_val, r_shift[DATA_WIDTH-1:1]};
          if (r_bit_cnt == c_last_bit) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = r_par_en ? PARITY : STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + c_cnt_w'(1);
          end
        end
      end
      PARITY: begin
        if (w_bit_done) begin
          w_par_pend_nxt = w_bit_val != ((^r_shift) ^ (r_par_typ == PARITY_ODD));
          w_state_nxt    = STOP;
        end
      end
      STOP: begin
        if (w_bit_done) begin
          w_par_err_nxt    = r_par_pend;
          w_stp_err_nxt    = !w_bit_val;
          w_data_valid_nxt = !r_par_pend && w_bit_val;
          if (!r_par_pend && w_bit_val) begin
            w_p_data_nxt = r_shift;
          end
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign p_data     = r_p_data;
  assign data_valid = r_data_valid;
  assign par_err    = r_par_err;
  assign stp_err    = r_stp_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
// +--------------------------------------------------------------------+
// | tb_uart_rx_fsm : directed self-checking bench for uart_rx_fsm      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx_fsm;
  import uart_rx_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dv_cnt = 0;
  int pe_cnt = 0;
  int se_cnt = 0;
  int dv_cyc = -1;
  logic [7:0] dv_q[$];

  uart_rx_fsm #(
    .DATA_WIDTH (8),
    .PRESCALE_W (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .prescale   (prescale),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder, sampled 1 ns after the active edge.
  always @(posedge clk) begin
    #1;
    if (data_valid === 1'b1) begin
      dv_cnt = dv_cnt + 1;
      dv_cyc = cyc;
      dv_q.push_back(p_data);
    end
    if (par_err === 1'b1) pe_cnt = pe_cnt + 1;
    if (stp_err === 1'b1) se_cnt = se_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pop_dv();
    if (dv_q.size() == 0) return 'x;
    return {24'b0, dv_q.pop_front()};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic b, input int n);
    rx_in = b;
    tick(n);
  endtask

  // noisy: corrupt one of the three sample points per data bit, rotating position.
  task automatic send_frame(input logic [7:0] d, input int p, input logic with_par,
                            input logic par_bit, input logic stop_bit, input logic noisy,
                            output int t0);
    rx_in = 1'b0;
    t0 = cyc;
    tick(p);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < p; j++) begin
        rx_in = (noisy && j == p / 2 + (i % 3)) ? ~d[i] : d[i];
        tick(1);
      end
    end
    if (with_par) hold(par_bit, p);
    hold(stop_bit, p);
    rx_in = 1'b1;
  endtask

  initial begin
    int t0;
    int t1;

    tick(3);
    chk("reset_p_data", {24'b0, p_data}, 32'h0);
    chk("reset_data_valid", {31'b0, data_valid}, 32'h0);
    chk("reset_par_err", {31'b0, par_err}, 32'h0);
    chk("reset_stp_err", {31'b0, stp_err}, 32'h0);
    chk("reset_state", {29'b0, dut.r_state}, {29'b0, ST_IDLE});
    rst = 1'b1;
    tick(3);

    prescale = 6'd8;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, t0);
    tick(4);
    chk("p8_dv_count", dv_cnt, 1);
    chk("p8_data", pop_dv(), 32'hA5);
    chk("p8_latency", dv_cyc, t0 + 81);
    chk("p8_no_par_err", pe_cnt, 0);
    chk("p8_no_stp_err", se_cnt, 0);

    prescale = 6'd16;
    par_en   = 1'b1;
    par_typ  = 1'b0;
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0, t0);
    tick(4);
    chk("par_ok_dv_count", dv_cnt, 2);
    chk("par_ok_data", pop_dv(), 32'h3C);
    chk("par_ok_latency", dv_cyc, t0 + 177);
    chk("par_ok_no_par_err", pe_cnt, 0);

    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b0, t0);
    tick(4);
    chk("par_bad_par_err", pe_cnt, 1);
    chk("par_bad_no_dv", dv_cnt, 2);
    chk("par_bad_p_data_held", {24'b0, p_data}, 32'h3C);
    chk("par_bad_no_stp_err", se_cnt, 0);

    par_en   = 1'b0;
    prescale = 6'd32;
    send_frame(8'h55, 32, 1'b0, 1'b0, 1'b0, 1'b0, t0);
    tick(4);
    chk("stop_bad_stp_err", se_cnt, 1);
    chk("stop_bad_no_dv", dv_cnt, 2);
    chk("stop_bad_p_data_held", {24'b0, p_data}, 32'h3C);
    chk("stop_bad_no_par_err", pe_cnt, 1);

    prescale = 6'd16;
    hold(1'b0, 3);
    hold(1'b1, 20);
    chk("glitch_state_idle", {29'b0, dut.r_state}, {29'b0, ST_IDLE});
    chk("glitch_no_dv", dv_cnt, 2);
    chk("glitch_no_stp_err", se_cnt, 1);
    send_frame(8'h81, 16, 1'b0, 1'b0, 1'b1, 1'b0, t0);
    tick(4);
    chk("after_glitch_dv_count", dv_cnt, 3);
    chk("after_glitch_data", pop_dv(), 32'h81);

    send_frame(8'hF0, 16, 1'b0, 1'b0, 1'b1, 1'b1, t0);
    tick(4);
    chk("noise_dv_count", dv_cnt, 4);
    chk("noise_data", pop_dv(), 32'hF0);

    // Unsupported ratio falls back to 8.
    prescale = 6'd12;
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, t0);
    tick(4);
    chk("bad_prescale_dv_count", dv_cnt, 5);
    chk("bad_prescale_data", pop_dv(), 32'h5A);

    prescale = 6'd16;
    send_frame(8'h12, 16, 1'b0, 1'b0, 1'b1, 1'b0, t0);
    send_frame(8'h34, 16, 1'b0, 1'b0, 1'b1, 1'b0, t1);
    hold(1'b0, 16);
    hold(1'b1, 48);
    chk("b2b_dv_count", dv_cnt, 7);
    chk("b2b_first", pop_dv(), 32'h12);
    chk("b2b_second", pop_dv(), 32'h34);
    chk("mid_frame_state_data", {29'b0, dut.r_state}, {29'b0, ST_DATA});
    rst = 1'b0;
    tick(1);
    chk("midrst_p_data", {24'b0, p_data}, 32'h0);
    chk("midrst_data_valid", {31'b0, data_valid}, 32'h0);
    chk("midrst_par_err", {31'b0, par_err}, 32'h0);
    chk("midrst_stp_err", {31'b0, stp_err}, 32'h0);
    chk("midrst_state", {29'b0, dut.r_state}, {29'b0, ST_IDLE});
    rst   = 1'b1;
    rx_in = 1'b1;
    tick(200);
    chk("post_rst_no_dv", dv_cnt, 7);
    chk("post_rst_no_stp_err", se_cnt, 1);
    chk("post_rst_no_par_err", pe_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
